// File: rtl/store_narrower.sv
// -----------------------------------------------------------------------------
// store_narrower
//   Store-path data narrower between the EX/MEM store path and the data-memory
//   write port. Converts a 32-bit register value, a byte address and a size
//   (byte/half/word) into word-aligned memory writes. Each write carries byte
//   enables and lane-replicated (or rotated) data. The block stalls the
//   pipeline through store_ready while a write is outstanding.
//
//   Build option: STORE_NARROWER_MISALIGNED_SPLIT_EN
//     undefined : misaligned half/word stores are rejected with store_err.
//     defined   : a misaligned half inside one word becomes a single access.
//                 Stores crossing a word boundary are split into two accesses.
//
//   Ports
//     clock, reset               : clock, async active-high reset
//     store_valid / store_ready  : request handshake from the pipeline
//     store_addr/data/size       : byte address, register value, 00 b/01 h/10 w
//     mem_req / mem_ack          : write request, held until acknowledged
//     mem_addr/mem_wdata/mem_be  : registered, word-aligned write beat
//     store_done                 : 1-cycle pulse when the store has fully completed
//     store_err                  : 1-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module store_narrower #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              store_valid,
   output logic              store_ready,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [31:0]       store_data,
   input  logic [1:0]        store_size,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   output logic              store_done,
   output logic              store_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE1 = 2'd1,
      S_ISSUE2 = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Increment for the word index. The second beat of a split wraps modulo 2^ADDR_W.
   localparam logic [ADDR_W-3:0] WORD_ONE = 1;

   state_t r_state;
   state_t w_next;

   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_be;
   logic              r_done;
   logic              r_err;
   logic              r_split;
   logic [3:0]        r_be2;

   logic [1:0]        w_k;
   logic [31:0]       w_rot;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be1;
   logic [3:0]        w_be2;
   logic              w_legal;
   logic              w_split;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_addr2;
   logic              w_accept;
   logic              w_reject;
   logic              w_advance;
   logic              w_finish;

   // ---------------------------------------------------------------------------
   // Request decode (only meaningful in IDLE; ignored elsewhere)
   // ---------------------------------------------------------------------------
   assign w_k    = store_addr[1:0];
   assign w_base = {store_addr[ADDR_W-1:2], 2'b00};

   // Rotate left by 8*k. Each byte of the register lands on the lane its
   // byte address selects. This is also correct for the split/unaligned cases.
   always_comb begin
      w_rot = store_data;
      case (w_k)
         2'd1:    w_rot = {store_data[23:0], store_data[31:24]};
         2'd2:    w_rot = {store_data[15:0], store_data[31:16]};
         2'd3:    w_rot = {store_data[7:0],  store_data[31:8]};
         default: w_rot = store_data;
      endcase
   end

   always_comb begin
      w_legal = 1'b0;
      w_split = 1'b0;
      w_be1   = 4'b0000;
      w_be2   = 4'b0000;
      w_wdata = w_rot;
      case (store_size)
         SZ_BYTE: begin
            w_legal = 1'b1;
            w_be1   = 4'b0001 << w_k;
            w_wdata = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            if (!w_k[0]) begin
               w_legal = 1'b1;
               w_be1   = 4'b0011 << w_k;
               w_wdata = {2{store_data[15:0]}};
            end else begin
`ifdef STORE_NARROWER_MISALIGNED_SPLIT_EN
               w_legal = 1'b1;
               if (w_k == 2'd1) begin
                  w_be1 = 4'b0110;
               end else begin
                  // k = 3: low byte in lane 3 of this word, high byte in lane 0 of next
                  w_split = 1'b1;
                  w_be1   = 4'b1000;
                  w_be2   = 4'b0001;
               end
`endif
            end
         end
         SZ_WORD: begin
            if (w_k == 2'd0) begin
               w_legal = 1'b1;
               w_be1   = 4'b1111;
               w_wdata = store_data;
            end else begin
`ifdef STORE_NARROWER_MISALIGNED_SPLIT_EN
               w_legal = 1'b1;
               w_split = 1'b1;
               w_be1   = 4'b1111 << w_k;
               w_be2   = 4'b1111 >> (3'd4 - {1'b0, w_k});
`endif
            end
         end
         default: begin
            w_legal = 1'b0;   // size 11 is reserved in every build
         end
      endcase
   end

   assign w_addr2 = {r_mem_addr[ADDR_W-1:2] + WORD_ONE, 2'b00};

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_reject  = 1'b0;
      w_advance = 1'b0;
      w_finish  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (store_valid) begin
               if (w_legal) begin
                  w_accept = 1'b1;
                  w_next   = S_ISSUE1;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         S_ISSUE1: begin
            if (mem_ack) begin
               if (r_split) begin
                  w_advance = 1'b1;
                  w_next    = S_ISSUE2;
               end else begin
                  w_finish = 1'b1;
                  w_next   = S_IDLE;
               end
            end
         end
         S_ISSUE2: begin
            if (mem_ack) begin
               w_finish = 1'b1;
               w_next   = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered memory beat and status pulses
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_split     <= 1'b0;
         r_be2       <= '0;
      end else begin
         r_done <= w_finish;
         r_err  <= w_reject;
         if (w_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_base;
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be1;
            r_split     <= w_split;
            r_be2       <= w_be2;
         end else if (w_advance) begin
            // req stays high: the second beat follows with no idle cycle, and the data is unchanged
            r_mem_addr <= w_addr2;
            r_mem_be   <= r_be2;
         end else if (w_finish) begin
            r_mem_req <= 1'b0;
         end
      end
   end

   assign store_ready = (r_state == S_IDLE);
   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_be      = r_mem_be;
   assign store_done  = r_done;
   assign store_err   = r_err;

endmodule

// File: tb/tb_store_narrower.sv
module tb_store_narrower;

   localparam int K_MEM  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        store_valid;
   logic        store_ready;
   logic [31:0] store_addr;
   logic [31:0] store_data;
   logic [1:0]  store_size;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        store_done;
   logic        store_err;

   exp_t q[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   ack_delay = 0;
   int   ack_cnt   = 0;
   int   req_cycles = 0;

   store_narrower #(.ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .store_valid(store_valid), .store_ready(store_ready),
      .store_addr(store_addr), .store_data(store_data), .store_size(store_size),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .store_done(store_done), .store_err(store_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic push_mem(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      exp_t e;
      e.kind = K_MEM; e.addr = a; e.be = be; e.wdata = wd;
      q.push_back(e);
   endtask

   task automatic push_ev(input int kind);
      exp_t e;
      e.kind = kind; e.addr = '0; e.be = '0; e.wdata = '0;
      q.push_back(e);
   endtask

   // Memory model: acknowledges ack_delay cycles after the request is seen.
   always @(posedge clock) begin
      #1;
      if (reset) begin
         mem_ack = 1'b0;
         ack_cnt = 0;
      end else begin
         if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
         end
         if (mem_req) begin
            if (ack_cnt >= ack_delay) mem_ack = 1'b1;
            else ack_cnt++;
         end
      end
   end

   // Monitor: pops the expected event whenever the DUT shows a done, err or memory beat.
   always @(negedge clock) begin
      if (!reset) begin
         if (store_done) begin
            if (q.size() == 0) chk("done_with_empty_queue", 32'(q.size()), 32'd1);
            else begin
               chk("done_kind", 32'(q[0].kind), 32'(K_DONE));
               void'(q.pop_front());
            end
         end
         if (store_err) begin
            if (q.size() == 0) chk("err_with_empty_queue", 32'(q.size()), 32'd1);
            else begin
               chk("err_kind", 32'(q[0].kind), 32'(K_ERR));
               void'(q.pop_front());
            end
         end
         if (mem_req) begin
            req_cycles++;
            if (q.size() == 0) chk("req_with_empty_queue", 32'(q.size()), 32'd1);
            else begin
               chk("mem_kind", 32'(q[0].kind), 32'(K_MEM));
               chk("mem_addr", mem_addr, q[0].addr);
               chk("mem_be", 32'(mem_be), 32'(q[0].be));
               chk("mem_wdata", mem_wdata, q[0].wdata);
               if (mem_ack) void'(q.pop_front());
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int n = 0;
      while (!store_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      chk("ready_before_issue", 32'(store_ready), 32'd1);
      store_valid = 1'b1; store_addr = a; store_data = d; store_size = sz;
      @(posedge clock); #1;
      store_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int exp_lat);
      int c = 1;
      while (!store_done && c < 60) begin
         @(posedge clock); #1; c++;
      end
      chk(nm, 32'(c), 32'(exp_lat));
   endtask

   task automatic check_err(input string nm);
      chk({nm, "_err"}, 32'(store_err), 32'd1);
      chk({nm, "_req"}, 32'(mem_req), 32'd0);
      chk({nm, "_ready"}, 32'(store_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1; store_valid = 1'b0; store_addr = '0; store_data = '0;
      store_size = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", 32'(store_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_done", 32'(store_done), 32'd0);
      chk("rst_err", 32'(store_err), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // byte store, immediate ack
      ack_delay = 0;
      push_mem(32'h0000_1000, 4'b0100, 32'h5A5A_5A5A); push_ev(K_DONE);
      issue(32'h0000_1002, 32'hDEAD_BE5A, 2'b00);
      wait_done("byte_latency", 2);

      // half store, ack delayed 3 cycles
      ack_delay = 3;
      req_cycles = 0;
      push_mem(32'h0000_2000, 4'b1100, 32'hC0DE_C0DE); push_ev(K_DONE);
      issue(32'h0000_2002, 32'h0000_C0DE, 2'b01);
      wait_done("half_latency", 5);
      chk("half_req_cycles", 32'(req_cycles), 32'd4);

      // misaligned word
      ack_delay = 0;
`ifdef STORE_NARROWER_MISALIGNED_SPLIT_EN
      push_mem(32'h0000_3000, 4'b1110, 32'h2233_4411);
      push_mem(32'h0000_3004, 4'b0001, 32'h2233_4411); push_ev(K_DONE);
      issue(32'h0000_3001, 32'h1122_3344, 2'b10);
      wait_done("split_word_latency", 3);

      push_mem(32'hFFFF_FFFC, 4'b1100, 32'hC3D4_A1B2);
      push_mem(32'h0000_0000, 4'b0011, 32'hC3D4_A1B2); push_ev(K_DONE);
      issue(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
      wait_done("wrap_latency", 3);

      push_mem(32'h0000_5000, 4'b0110, 32'h00BE_EF00); push_ev(K_DONE);
      issue(32'h0000_5001, 32'h0000_BEEF, 2'b01);
      wait_done("half_k1_latency", 2);

      push_mem(32'h0000_A000, 4'b1000, 32'hEF00_00BE);
      push_mem(32'h0000_A004, 4'b0001, 32'hEF00_00BE); push_ev(K_DONE);
      issue(32'h0000_A003, 32'h0000_BEEF, 2'b01);
      wait_done("half_k3_latency", 3);
`else
      push_ev(K_ERR);
      issue(32'h0000_3001, 32'h1122_3344, 2'b10);
      check_err("mis_word");
      push_ev(K_ERR);
      issue(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
      check_err("mis_word_wrap");
      push_ev(K_ERR);
      issue(32'h0000_5001, 32'h0000_BEEF, 2'b01);
      check_err("mis_half");
      @(posedge clock); #1;
      chk("mis_half_err_one_cycle", 32'(store_err), 32'd0);
`endif

      // reserved size, then a legal word presented in the err cycle
      push_ev(K_ERR);
      push_mem(32'h0000_4000, 4'b1111, 32'hCAFE_F00D); push_ev(K_DONE);
      issue(32'h0000_6000, 32'h0000_0055, 2'b11);
      check_err("size11");
      issue(32'h0000_4000, 32'hCAFE_F00D, 2'b10);
      wait_done("after_err_latency", 2);

      // back-to-back: second request in the done cycle
      push_mem(32'h0000_7000, 4'b1000, 32'h7777_7777); push_ev(K_DONE);
      issue(32'h0000_7003, 32'h0000_0077, 2'b00);
      wait_done("b2b_first_latency", 2);
      chk("b2b_ready_in_done", 32'(store_ready), 32'd1);
      push_mem(32'h0000_7000, 4'b0011, 32'h1234_1234); push_ev(K_DONE);
      issue(32'h0000_7000, 32'h0000_1234, 2'b01);
      wait_done("b2b_second_latency", 2);

      // reset while a transaction is outstanding
      ack_delay = 2;
`ifdef STORE_NARROWER_MISALIGNED_SPLIT_EN
      push_mem(32'h0000_8000, 4'b1000, 32'h4411_2233);
      push_mem(32'h0000_8004, 4'b0111, 32'h4411_2233); push_ev(K_DONE);
      issue(32'h0000_8003, 32'h1122_3344, 2'b10);
      begin
         int n = 0;
         while (mem_addr !== 32'h0000_8004 && n < 20) begin
            @(posedge clock); #1; n++;
         end
         chk("reached_issue2", mem_addr, 32'h0000_8004);
      end
`else
      ack_delay = 5;
      push_mem(32'h0000_8000, 4'b1111, 32'h1122_3344); push_ev(K_DONE);
      issue(32'h0000_8000, 32'h1122_3344, 2'b10);
`endif
      chk("req_before_reset", 32'(mem_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("reset_req_drop", 32'(mem_req), 32'd0);
      chk("reset_ready", 32'(store_ready), 32'd1);
      q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      ack_delay = 0;
      repeat (3) begin
         @(posedge clock); #1;
         chk("post_reset_no_done", 32'(store_done), 32'd0);
         chk("post_reset_no_err", 32'(store_err), 32'd0);
      end

      push_mem(32'h0000_9000, 4'b0010, 32'hABAB_ABAB); push_ev(K_DONE);
      issue(32'h0000_9001, 32'h0000_00AB, 2'b00);
      wait_done("post_reset_latency", 2);

      begin
         int n = 0;
         while (q.size() != 0 && n < 20) begin
            @(posedge clock); #1; n++;
         end
      end
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/store_narrower.md
# store_narrower

Store-path data narrower for the MIPS datapath: the write-side counterpart of the load sign/zero extender. It takes a 32-bit register value plus a byte address and size (byte, half, word). It produces word-aligned memory write transactions with byte enables and lane-replicated data, using a req/ack handshake to data memory. It sits between the EX/MEM store path and the data-memory port and stalls the pipeline through `store_ready` while a transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; memory address output is word aligned (bits [1:0] = 0).

Ports:
- `clock` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `store_valid` input 1: store request present.
- `store_ready` output 1: block can accept a request (high only in IDLE).
- `store_addr` input ADDR_W: byte address of the store.
- `store_data` input 32: register value; only the low 8/16 bits are used for byte/half.
- `store_size` input 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- `mem_req` output 1: memory write request, held until `mem_ack`.
- `mem_addr` output ADDR_W: word-aligned write address.
- `mem_wdata` output 32: write data, lane-aligned.
- `mem_be` output 4: byte enables; bit k enables lane k (`mem_wdata[8k+7:8k]`).
- `mem_ack` input 1: memory accepted the current write (sampled only while `mem_req` = 1).
- `store_done` output 1: one-cycle pulse when a store fully completes.
- `store_err` output 1: one-cycle pulse when a request is rejected; no memory access occurs.

## Operation
- Little-endian lanes; offset k = `store_addr[1:0]`, R = `store_data` rotated left by 8k bits.
- Byte: be = 0001<<k, wdata = {4{data[7:0]}}.
- Half, k even: be = 0011<<k, wdata = {2{data[15:0]}}.
- Word, k = 0: be = 1111, wdata = data.
- Misaligned half (k odd) or misaligned word (k ≠ 0): handled per Configuration.
- Size 11 is always an error.
- FSM states:
  - IDLE: `store_ready` = 1.
  - ISSUE1: first or only access.
  - ISSUE2: second access of a split.
- Transitions:
  - IDLE→ISSUE1: `store_valid` and the request is legal. Address, data, size and offset are latched.
  - IDLE→IDLE with `store_err` pulse: request is illegal.
  - ISSUE1→ISSUE2: on `mem_ack` when the request is a split.
  - ISSUE1→IDLE or ISSUE2→IDLE: on `mem_ack` when no further access is needed; `store_done` pulses.
- `mem_addr`, `mem_wdata` and `mem_be` are registered. They are stable for the whole time `mem_req` is high.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: `store_ready` = 1, `mem_req` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_be` = 0, `store_done` = 0, `store_err` = 0; state = IDLE.
- Request accepted at edge N → `mem_req` = 1 from cycle N+1. `mem_ack` is sampled at edge M, where M ≥ N+1.
- Single access:
  - `mem_req` = 0 from cycle M+1.
  - `store_done` = 1 for cycle M+1 only.
  - `store_ready` = 1 in cycle M+1.
  - Minimum latency is 2 cycles from accept to done (`mem_ack` tied high).
- Split access: `mem_req` stays high across the ISSUE1→ISSUE2 edge, with no idle gap. Address and enables switch at edge M.
- Back-to-back: a new request may be accepted in cycle M+1, the same cycle `store_done` is high.
- Illegal request at edge N: `store_err` = 1 for cycle N+1 only, `store_ready` stays 1, and `mem_req` stays 0.
- `reset` asserted mid-transaction: `mem_req` drops asynchronously and the partial store is abandoned. No `store_done` or `store_err` is issued.

## Configuration
- Macro: `STORE_NARROWER_MISALIGNED_SPLIT_EN`.
- Undefined: every misaligned half/word is illegal and produces `store_err`.
- Defined, misaligned access contained in one word (half at k = 1): single access, be = 0110, wdata = R.
- Defined, access crossing a word boundary (half k = 3; word k = 1, 2, 3): two accesses, both with wdata = R.
  - First access: `mem_addr` = A & ~3, be = (1111<<k)[3:0] for word, 1000 for half.
  - Second access: `mem_addr` = (A & ~3) + 4, wrapping modulo 2^ADDR_W; be = 1111>>(4−k) for word, 0001 for half.
- Defined, size 11: still illegal.

## Test plan
- Reset, then byte store addr 0x1002, data 0xDEADBE5A, ack immediate → mem_addr 0x1000, be 0100, wdata 0x5A5A5A5A, done pulse 2 cycles after accept.
- Half store addr 0x2002, data 0x0000C0DE, ack delayed 3 cycles → mem_req held 4 cycles with stable outputs, be 1100, wdata 0xC0DEC0DE.
- Word store addr 0x3001, data 0x11223344:
  - Macro undefined → err pulse next cycle, mem_req never rises.
  - Macro defined → access at 0x3000 with be 1110 and wdata 0x22334411, then access at 0x3004 with be 0001 and the same wdata, then one done pulse.
- Word store addr 0xFFFFFFFE with macro defined → second access mem_addr 0x00000000, be 0011.
- Size 11 at any address → err pulse and no memory traffic. A legal word store at 0x4000 presented in the err cycle is accepted and completes.
- Reset asserted while mem_req high in ISSUE2 → mem_req 0 within the same cycle, store_ready 1, no done/err. A following store behaves normally.
